// File: rtl/mips_defs.sv
// Shared MIPS32 core definitions used by the decode, register-file and write-back stages.
package mips_defs;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage : mips_defs

// File: rtl/hilo_reg.sv
// HI/LO multiply-result pair: written together, with a same-cycle bypass to the read side.
module hilo_reg
    import mips_defs::*;
#(
    parameter int unsigned DATA_W = mips_defs::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (whilo) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= DATA_W'(ZERO_WORD);
            lo_q <= DATA_W'(ZERO_WORD);
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Bypass lets an mfhi/mflo right after mult see the new product.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst) begin
            hi_o = DATA_W'(ZERO_WORD);
            lo_o = DATA_W'(ZERO_WORD);
        end else if (whilo) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule : hilo_reg

// File: rtl/regfile.sv
// MIPS32 general-purpose register file ($0 hardwired to zero), two async read ports
// with write-back bypass, plus the HI/LO pair.
module regfile
    import mips_defs::*;
#(
    parameter int unsigned DATA_W = mips_defs::DATA_W,
    parameter int unsigned ADDR_W = mips_defs::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rreg1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic              rreg2,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != ADDR_W'(REG_ZERO))) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[ADDR_W'(i)] <= DATA_W'(ZERO_WORD);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Address 0 is forced to zero ahead of the bypass so a discarded $0 write never leaks.
    always_comb begin
        if (rst || !rreg1 || (ra1 == ADDR_W'(REG_ZERO))) begin
            rd1 = DATA_W'(ZERO_WORD);
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs_q[ra1];
        end
    end

    always_comb begin
        if (rst || !rreg2 || (ra2 == ADDR_W'(REG_ZERO))) begin
            rd2 = DATA_W'(ZERO_WORD);
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs_q[ra2];
        end
    end

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .whilo(whilo),
        .hi_i (hi_i),
        .lo_i (lo_i),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, write/read, $0, bypass, enables, HI/LO.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        rreg1;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic        rreg2;
    logic [4:0]  ra2;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks;
    int errors;

    regfile #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rreg1(rreg1),
        .ra1  (ra1),
        .rd1  (rd1),
        .rreg2(rreg2),
        .ra2  (ra2),
        .rd2  (rd2),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .whilo(whilo),
        .hi_i (hi_i),
        .lo_i (lo_i),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst   = 1'b0;
        we    = 1'b0;
        wa    = 5'd0;
        wd    = 32'h0;
        whilo = 1'b0;
        hi_i  = 32'h0;
        lo_i  = 32'h0;
        rreg1 = 1'b1;
        rreg2 = 1'b1;
        ra1   = 5'd0;
        ra2   = 5'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        tick();
        idle();

        // Fill every register and HI/LO with ones.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1;
            wa = 5'(i);
            wd = 32'hFFFF_FFFF;
            tick();
        end
        we    = 1'b0;
        whilo = 1'b1;
        hi_i  = 32'hFFFF_FFFF;
        lo_i  = 32'hFFFF_FFFF;
        tick();
        idle();
        ra1 = 5'd5;
        ra2 = 5'd31;
        #1;
        check("prefill_rd1", rd1, 32'hFFFF_FFFF);
        check("prefill_rd2", rd2, 32'hFFFF_FFFF);
        check("prefill_hi", hi_o, 32'hFFFF_FFFF);

        // Outputs read zero while reset is asserted, and writes in that cycle are dropped.
        rst   = 1'b1;
        we    = 1'b1;
        wa    = 5'd7;
        wd    = 32'h1357_9BDF;
        whilo = 1'b1;
        hi_i  = 32'h1111_1111;
        lo_i  = 32'h2222_2222;
        #1;
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            check($sformatf("post_rst_rd1[%0d]", i), rd1, 32'h0);
            check($sformatf("post_rst_rd2[%0d]", 31 - i), rd2, 32'h0);
        end
        check("post_rst_hi", hi_o, 32'h0);
        check("post_rst_lo", lo_o, 32'h0);

        // Basic write then read.
        we = 1'b1;
        wa = 5'd8;
        wd = 32'h1234_5678;
        tick();
        idle();
        ra1 = 5'd8;
        ra2 = 5'd9;
        #1;
        check("wr8_rd1", rd1, 32'h1234_5678);
        check("wr8_rd2_other", rd2, 32'h0);

        // $0 write is discarded, both in bypass and in storage.
        we  = 1'b1;
        wa  = 5'd0;
        wd  = 32'hDEAD_BEEF;
        ra2 = 5'd0;
        #1;
        check("zero_bypass_rd2", rd2, 32'h0);
        tick();
        idle();
        ra2 = 5'd0;
        #1;
        check("zero_store_rd2", rd2, 32'h0);

        // Bypass on both ports.
        we = 1'b1;
        wa = 5'd9;
        wd = 32'h0000_0001;
        tick();
        idle();
        ra1 = 5'd9;
        ra2 = 5'd9;
        #1;
        check("r9_init_rd1", rd1, 32'h0000_0001);
        we = 1'b1;
        wa = 5'd9;
        wd = 32'hCAFE_0000;
        #1;
        check("byp_rd1", rd1, 32'hCAFE_0000);
        check("byp_rd2", rd2, 32'hCAFE_0000);
        tick();
        idle();
        ra1 = 5'd9;
        ra2 = 5'd9;
        #1;
        check("byp_hold_rd1", rd1, 32'hCAFE_0000);
        check("byp_hold_rd2", rd2, 32'hCAFE_0000);

        // Bypass on one port only; the other reads storage.
        we  = 1'b1;
        wa  = 5'd8;
        wd  = 32'h0BAD_F00D;
        ra1 = 5'd8;
        ra2 = 5'd9;
        #1;
        check("byp_one_rd1", rd1, 32'h0BAD_F00D);
        check("byp_one_rd2", rd2, 32'hCAFE_0000);
        tick();
        idle();

        // Read enables gate each port independently.
        we = 1'b1;
        wa = 5'd3;
        wd = 32'hA5A5_A5A5;
        tick();
        idle();
        ra1   = 5'd3;
        ra2   = 5'd3;
        rreg1 = 1'b0;
        rreg2 = 1'b1;
        #1;
        check("en_rd1_off", rd1, 32'h0);
        check("en_rd2_on", rd2, 32'hA5A5_A5A5);
        rreg1 = 1'b1;
        rreg2 = 1'b0;
        #1;
        check("en_rd1_on", rd1, 32'hA5A5_A5A5);
        check("en_rd2_off", rd2, 32'h0);
        rreg2 = 1'b1;

        // HI/LO bypass, then hold.
        whilo = 1'b1;
        hi_i  = 32'h0000_0002;
        lo_i  = 32'h8000_0000;
        #1;
        check("hilo_byp_hi", hi_o, 32'h0000_0002);
        check("hilo_byp_lo", lo_o, 32'h8000_0000);
        tick();
        idle();
        hi_i = 32'h7777_7777;
        lo_i = 32'h6666_6666;
        #1;
        check("hilo_hold_hi", hi_o, 32'h0000_0002);
        check("hilo_hold_lo", lo_o, 32'h8000_0000);

        // Simultaneous register and HI/LO writes.
        we    = 1'b1;
        wa    = 5'd10;
        wd    = 32'h0F0F_F0F0;
        whilo = 1'b1;
        hi_i  = 32'h0000_0003;
        lo_i  = 32'h4000_0001;
        tick();
        idle();
        ra1 = 5'd10;
        ra2 = 5'd3;
        #1;
        check("dual_rd1", rd1, 32'h0F0F_F0F0);
        check("dual_rd2", rd2, 32'hA5A5_A5A5);
        check("dual_hi", hi_o, 32'h0000_0003);
        check("dual_lo", lo_o, 32'h4000_0001);

        // Reset with a write in flight: the write is lost.
        we = 1'b1;
        wa = 5'd4;
        wd = 32'h1111_1111;
        tick();
        idle();
        rst = 1'b1;
        we  = 1'b1;
        wa  = 5'd4;
        wd  = 32'h5555_5555;
        tick();
        idle();
        ra1 = 5'd4;
        ra2 = 5'd10;
        #1;
        check("rst_wr_rd1", rd1, 32'h0);
        check("rst_wr_rd2", rd2, 32'h0);
        check("rst_wr_hi", hi_o, 32'h0);

        // First edge after reset release accepts writes.
        we = 1'b1;
        wa = 5'd4;
        wd = 32'h5555_5555;
        tick();
        idle();
        ra1 = 5'd4;
        #1;
        check("after_rst_rd1", rd1, 32'h5555_5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile
